// File: rtl/uart_pkg.sv
// Shared types and helpers for the parameterised UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_RSVD = 2'b11
    } parity_mode_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Received-word handshake: the receiver holds a word plus status until the consumer takes it.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_data_valid;
    logic                 rx_data_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 parity_error;
    logic                 framing_error;
    logic                 break_detected;

    modport master (
        output rx_data_valid,
        output rx_data,
        output parity_error,
        output framing_error,
        output break_detected,
        input  rx_data_ready
    );

    modport slave (
        input  rx_data_valid,
        input  rx_data,
        input  parity_error,
        input  framing_error,
        input  break_detected,
        output rx_data_ready
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sin,
    output logic sin_sync
);
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sin};
        end
    end

    assign sin_sync = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: majority-voted bit sampling, optional parity, one/two stop bits,
// break detection and a single-word holding register with overrun reporting.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck_rising_edge,
    input  logic       sin,
    input  logic [1:0] parity_mode,
    input  logic       two_stop,
    output logic       busy,
    output logic       overrun,
    uart_rx_param_if.master rx_if
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] CNT_S0   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] CNT_S1   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] CNT_DEC  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] CNT_END  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic sin_s;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .sin      (sin),
        .sin_sync (sin_s)
    );

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    parity_mode_t         pmode_q, pmode_d;
    logic                 two_stop_q, two_stop_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop0_low_q, stop0_low_d;
    logic                 smp0_q, smp0_d, smp1_q, smp1_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;

    logic                 valid_q, valid_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ferr_out_q, ferr_out_d;
    logic                 brk_out_q, brk_out_d;
    logic                 ovr_q, ovr_d;

    logic maj, at_s0, at_s1, at_dec, at_end, has_par, exp_par, last_stop;
    logic frame_done, done_ferr, done_brk, done_stop0_low;

    assign maj       = majority3(smp0_q, smp1_q, sin_s);
    assign at_s0     = (tick_q == CNT_S0);
    assign at_s1     = (tick_q == CNT_S1);
    assign at_dec    = (tick_q == CNT_DEC);
    assign at_end    = (tick_q == CNT_END);
    assign has_par   = (pmode_q == PAR_EVEN) || (pmode_q == PAR_ODD);
    assign exp_par   = (pmode_q == PAR_ODD) ? ~(^shift_q) : (^shift_q);
    assign last_stop = two_stop_q ? (bit_q == BW'(1)) : (bit_q == '0);

    // Completion status folds in the final stop sample, which is not yet registered.
    assign done_ferr      = frm_err_q | ~maj;
    assign done_stop0_low = (bit_q == '0) ? ~maj : stop0_low_q;
    assign done_brk       = (shift_q == '0) && !par_bit_q && done_stop0_low;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            pmode_q     <= PAR_NONE;
            two_stop_q  <= 1'b0;
            par_err_q   <= 1'b0;
            frm_err_q   <= 1'b0;
            par_bit_q   <= 1'b0;
            stop0_low_q <= 1'b0;
            valid_q     <= 1'b0;
            dout_q      <= '0;
            perr_out_q  <= 1'b0;
            ferr_out_q  <= 1'b0;
            brk_out_q   <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            pmode_q     <= pmode_d;
            two_stop_q  <= two_stop_d;
            par_err_q   <= par_err_d;
            frm_err_q   <= frm_err_d;
            par_bit_q   <= par_bit_d;
            stop0_low_q <= stop0_low_d;
            valid_q     <= valid_d;
            dout_q      <= dout_d;
            perr_out_q  <= perr_out_d;
            ferr_out_q  <= ferr_out_d;
            brk_out_q   <= brk_out_d;
            ovr_q       <= ovr_d;
        end
    end

    // Sample and shift registers are always written before they are used in a frame.
    always_ff @(posedge clk) begin
        smp0_q  <= smp0_d;
        smp1_q  <= smp1_d;
        shift_q <= shift_d;
    end

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        pmode_d     = pmode_q;
        two_stop_d  = two_stop_q;
        par_err_d   = par_err_q;
        frm_err_d   = frm_err_q;
        par_bit_d   = par_bit_q;
        stop0_low_d = stop0_low_q;
        smp0_d      = smp0_q;
        smp1_d      = smp1_q;
        shift_d     = shift_q;
        frame_done  = 1'b0;

        if (sck_rising_edge) begin
            if (state_q != IDLE) begin
                tick_d = at_end ? '0 : tick_q + TW'(1);
                if (at_s0) smp0_d = sin_s;
                if (at_s1) smp1_d = sin_s;
            end
            unique case (state_q)
                IDLE: begin
                    if (!sin_s) begin
                        state_d     = START;
                        tick_d      = '0;
                        bit_d       = '0;
                        pmode_d     = parity_mode_t'(parity_mode);
                        two_stop_d  = two_stop;
                        par_err_d   = 1'b0;
                        frm_err_d   = 1'b0;
                        par_bit_d   = 1'b0;
                        stop0_low_d = 1'b0;
                    end
                end
                START: begin
                    if (at_dec && maj) begin
                        state_d = IDLE;
                        tick_d  = '0;
                    end else if (at_end) begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (at_dec) shift_d = {maj, shift_q[DATA_BITS-1:1]};
                    if (at_end) begin
                        if (bit_q == LAST_BIT) begin
                            bit_d   = '0;
                            state_d = has_par ? PARITY : STOP;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (at_dec) begin
                        par_bit_d = maj;
                        par_err_d = (maj != exp_par);
                    end
                    if (at_end) state_d = STOP;
                end
                STOP: begin
                    if (at_dec) begin
                        frm_err_d   = done_ferr;
                        stop0_low_d = done_stop0_low;
                        if (last_stop) begin
                            frame_done = 1'b1;
                            state_d    = IDLE;
                            tick_d     = '0;
                        end
                    end else if (at_end) begin
                        bit_d = bit_q + BW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Holding register: a completed frame loads unless a pending word is not being taken.
    always_comb begin
        valid_d    = valid_q;
        dout_d     = dout_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        brk_out_d  = brk_out_q;
        ovr_d      = 1'b0;
        if (frame_done && valid_q && !rx_if.rx_data_ready) begin
            ovr_d = 1'b1;
        end else if (frame_done) begin
            valid_d    = 1'b1;
            dout_d     = shift_q;
            perr_out_d = par_err_q;
            ferr_out_d = done_ferr;
            brk_out_d  = done_brk;
        end else if (valid_q && rx_if.rx_data_ready) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        busy                 = (state_q != IDLE);
        overrun              = ovr_q;
        rx_if.rx_data_valid  = valid_q;
        rx_if.rx_data        = dout_q;
        rx_if.parity_error   = perr_out_q;
        rx_if.framing_error  = ferr_out_q;
        rx_if.break_detected = brk_out_q;
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed scoreboard bench for uart_rx_param (8 data bits, 16x oversampling).
module tb_uart_rx_param;
    logic       clk;
    logic       rst;
    logic       sck;
    logic       sin;
    logic [1:0] parity_mode;
    logic       two_stop;
    logic       busy;
    logic       overrun;

    uart_rx_param_if #(.DATA_BITS(8)) rx_if ();

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .sck_rising_edge (sck),
        .sin             (sin),
        .parity_mode     (parity_mode),
        .two_stop        (two_stop),
        .busy            (busy),
        .overrun         (overrun),
        .rx_if           (rx_if)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ovr_seen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One oversample tick every fourth clock.
    initial begin
        sck = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            sck = 1'b1;
            @(negedge clk);
            sck = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare each word at the cycle it is handed over, and count overrun pulses.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rx_if.rx_data_valid && rx_if.rx_data_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none", rx_if.rx_data);
                end else begin
                    e = sb.pop_front();
                    check("word_data", 32'(rx_if.rx_data), 32'(e.data));
                    check("word_parity_error", 32'(rx_if.parity_error), 32'(e.perr));
                    check("word_framing_error", 32'(rx_if.framing_error), 32'(e.ferr));
                    check("word_break", 32'(rx_if.break_detected), 32'(e.brk));
                end
            end
            if (overrun) ovr_seen++;
        end
    end

    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (sck) k++;
        end
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_en, input logic par_bit,
                              input int nstop);
        sin = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            sin = d[i];
            wait_ticks(16);
        end
        if (par_en) begin
            sin = par_bit;
            wait_ticks(16);
        end
        sin = 1'b1;
        wait_ticks(16 * nstop);
        wait_ticks(32);
    endtask

    task automatic wait_valid_low(input int maxc);
        int n = 0;
        while (rx_if.rx_data_valid && n < maxc) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("valid_drop", 32'(rx_if.rx_data_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        sin = 1'b1;
        parity_mode = 2'b00;
        two_stop = 1'b0;
        rx_if.rx_data_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(rx_if.rx_data_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_data", 32'(rx_if.rx_data), 32'd0);
        check("rst_flags", {29'd0, rx_if.parity_error, rx_if.framing_error, rx_if.break_detected}, 32'd0);
        rst = 1'b0;
        wait_ticks(8);

        // 8N1 0x55 held until the consumer is ready.
        sb.push_back('{data: 8'h55, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
        send_frame(8'h55, 1'b0, 1'b0, 1);
        check("hold_valid", 32'(rx_if.rx_data_valid), 32'd1);
        repeat (40) @(posedge clk);
        #1;
        check("hold_valid_later", 32'(rx_if.rx_data_valid), 32'd1);
        check("hold_data", 32'(rx_if.rx_data), 32'h55);
        rx_if.rx_data_ready = 1'b1;
        wait_valid_low(10);

        // Even parity, wrong parity bit.
        parity_mode = 2'b01;
        sb.push_back('{data: 8'hA3, perr: 1'b1, ferr: 1'b0, brk: 1'b0});
        send_frame(8'hA3, 1'b1, 1'b1, 1);

        // Odd parity, correct bit, two stop bits.
        parity_mode = 2'b10;
        two_stop = 1'b1;
        sb.push_back('{data: 8'hC4, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
        send_frame(8'hC4, 1'b1, 1'b0, 2);
        parity_mode = 2'b00;
        two_stop = 1'b0;

        // Glitch of four ticks is rejected as a false start.
        sin = 1'b0;
        wait_ticks(4);
        sin = 1'b1;
        wait_ticks(12);
        check("false_start_busy", 32'(busy), 32'd0);
        check("false_start_valid", 32'(rx_if.rx_data_valid), 32'd0);
        wait_ticks(32);

        // Break: line low for 12 bit times; the restart that follows is cut by reset.
        sb.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b1, brk: 1'b1});
        sin = 1'b0;
        wait_ticks(16 * 12);
        sin = 1'b1;
        wait_ticks(4);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_break_busy", 32'(busy), 32'd0);
        wait_ticks(32);

        // Two frames without consumer: the second is discarded with one overrun pulse.
        rx_if.rx_data_ready = 1'b0;
        sb.push_back('{data: 8'h12, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
        send_frame(8'h12, 1'b0, 1'b0, 1);
        send_frame(8'h34, 1'b0, 1'b0, 1);
        check("overrun_valid", 32'(rx_if.rx_data_valid), 32'd1);
        check("overrun_data", 32'(rx_if.rx_data), 32'h12);
        rx_if.rx_data_ready = 1'b1;
        wait_valid_low(10);

        // Reset in the middle of 0x7E, then a clean 0x81.
        sin = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            sin = (8'h7E >> i) & 8'h01;
            wait_ticks(16);
        end
        sin = 1'b1;
        wait_ticks(8);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        wait_ticks(32);
        sb.push_back('{data: 8'h81, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
        send_frame(8'h81, 1'b0, 1'b0, 1);

        repeat (10) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        check("overrun_pulses", 32'(ovr_seen), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, sck_rising_edge ticks per bit, even, legal 8..32.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, sin synchroniser depth, legal 2..4.
REQ-004 SHALL have ports:
  clk  in  1  sole clock; one clock, all logic on posedge clk
  rst  in  1  reset, synchronous, active-high
  sck_rising_edge  in  1  one-cycle tick at OVERSAMPLE x baud
  sin  in  1  asynchronous serial line, idle high
  parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
  two_stop  in  1  1 = two stop bits expected
  rx_data_ready  in  1  consumer accepts held word
  busy  out  1  high whenever state != IDLE
  rx_data_valid  out  1  held word available
  rx_data  out  DATA_BITS  received word, LSB first on the line
  parity_error  out  1  parity mismatch for held word
  framing_error  out  1  a stop sample low for held word
  break_detected  out  1  held word is a break condition
  overrun  out  1  one-cycle pulse, completed frame discarded

Function
REQ-005 sin SHALL pass through SYNC_STAGES flops before any use; all references below use the synchronised line.
REQ-006 FSM SHALL have states IDLE, START, DATA, PARITY, STOP; busy = (state != IDLE).
REQ-007 IDLE: synchronised sin low SHALL move to START, clear tick counter, clear bit counter, latch parity_mode and two_stop for the frame; later changes to these inputs mid-frame SHALL be ignored.
REQ-008 Tick counter, width $clog2(OVERSAMPLE), SHALL advance only on sck_rising_edge; a bit period spans counts 0..OVERSAMPLE-1.
REQ-009 Each bit value SHALL be the majority of samples taken at counts OS/2-1, OS/2, OS/2+1 (OS = OVERSAMPLE), decided on the tick at count OS/2+1.
REQ-010 START: majority high SHALL abort to IDLE (false start) with no output change; majority low SHALL continue to DATA at count OS-1.
REQ-011 DATA: SHALL shift DATA_BITS bits LSB first; after the last bit go to PARITY if the latched mode is even/odd, else to STOP.
REQ-012 PARITY: expected bit SHALL be XOR of data (even) or its inverse (odd); mismatch sets parity_error for this frame.
REQ-013 STOP: one or two (two_stop) stop samples; any low sample sets framing_error; the frame SHALL complete at the decision tick of the last stop bit (count OS/2+1) and return to IDLE that cycle for resync.
REQ-014 Break: all data bits 0, parity bit (if present) 0 and first stop sample 0 SHALL set break_detected together with framing_error.
REQ-015 Outputs SHALL update the cycle after the completing tick; rx_data, parity_error, framing_error, break_detected are qualified by rx_data_valid.
REQ-016 rx_data_valid SHALL stay high and the held word stable until a cycle with rx_data_valid and rx_data_ready, then drop next cycle unless a new frame loads.
REQ-017 Frame completing while held word pending and rx_data_ready low SHALL pulse overrun for one cycle, discard the new frame, keep the old word and flags.
REQ-018 Frame completing in the same cycle the held word is accepted SHALL load the new word, keep rx_data_valid high, no overrun.
REQ-019 sck_rising_edge low SHALL freeze the FSM and counters.

Reset
REQ-020 rst high at a clk edge SHALL force state IDLE, counters 0, all outputs 0, synchroniser flops 1; a frame in progress SHALL be dropped without rx_data_valid.
REQ-021 After rst deasserts, a line held low SHALL be treated as a new start edge.

Structure
REQ-022 Package uart_pkg SHALL hold state_t (IDLE, START, DATA, PARITY, STOP) and parity_mode_t enums.
REQ-023 Synchroniser SHALL be sub-module uart_rx_sync (SYNC_STAGES flops, reset value 1).

Verification (DATA_BITS=8, OVERSAMPLE=16)
REQ-024 8N1 frame 0x55 -> rx_data=0x55, rx_data_valid until ready, all error flags 0, overrun 0.
REQ-025 Even parity, frame 0xA3 with parity bit 1 (correct 0) -> rx_data=0xA3, parity_error=1, framing_error=0.
REQ-026 sin low for 4 ticks only -> no rx_data_valid, busy returns 0 by count 9 of START.
REQ-027 sin low for 12 bit times, 8N1 -> rx_data=0x00, framing_error=1, break_detected=1.
REQ-028 Frames 0x12 then 0x34, rx_data_ready=0 -> rx_data=0x12 retained, one overrun pulse; ready high -> valid drops.
REQ-029 rst pulsed during bit 4 of 0x7E, then clean 0x81 frame -> only 0x81 delivered, no error flags.
